chip_frame_driver: RTL and testbench

Host-side partner of the edge-detection CHIP interface. It accepts a 20x20 image of 5-bit pixels one per cycle from an upstream valid/ready stream and buffers the whole frame. It then bursts the frame into CHIP five pixels per cycle and asserts load_end on the last beat. Afterwards it collects the serial edge_out bits qualified by readable, packs them into 20-bit rows, and presents each row on a downstream valid/ready port.

---
 rtl/chip_frame_driver_if.sv | 44 ++++
 rtl/chip_frame_driver.sv | 182 ++++++++++++++++++
 tb/tb_chip_frame_driver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip_frame_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip_frame_driver_if : pixel stream in, CHIP burst/edge link, row stream out |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
interface chip_frame_driver_if #(
    parameter int BIT_LENGTH = 5,
    parameter int ROW_BITS   = 20
);
    logic                  s_valid;
    logic [BIT_LENGTH-1:0] s_pixel;
    logic                  s_ready;

    logic [BIT_LENGTH-1:0] pixel_out0;
    logic [BIT_LENGTH-1:0] pixel_out1;
    logic [BIT_LENGTH-1:0] pixel_out2;
    logic [BIT_LENGTH-1:0] pixel_out3;
    logic [BIT_LENGTH-1:0] pixel_out4;
    logic                  load_end;

    logic                  edge_in;
    logic                  readable_in;

    logic                  m_valid;
    logic [ROW_BITS-1:0]   m_row;
    logic                  m_ready;

    logic                  busy;
    logic                  overflow;

    // master is the driver block, slave is its environment
    modport master (
        input  s_valid, s_pixel, edge_in, readable_in, m_ready,
        output s_ready, pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
        output load_end, m_valid, m_row, busy, overflow
    );

    modport slave (
        output s_valid, s_pixel, edge_in, readable_in, m_ready,
        input  s_ready, pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
        input  load_end, m_valid, m_row, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/chip_frame_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip_frame_driver : buffers a frame, bursts it to CHIP, packs edge rows     |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module chip_frame_driver #(
    parameter int BIT_LENGTH = 5,
    parameter int IMG_DIM    = 20,
    parameter int LANES      = 5,
    parameter int ROW_BITS   = 20,
    parameter int EDGE_COUNT = 400
) (
    input  wire logic          clk,
    input  wire logic          reset,
    chip_frame_driver_if.master bus
);
    localparam int NPIX   = IMG_DIM * IMG_DIM;
    localparam int NBEATS = NPIX / LANES;
    localparam int PIX_W  = $clog2(NPIX);
    localparam int BEAT_W = $clog2(NBEATS);
    localparam int BIT_W  = $clog2(EDGE_COUNT + 1);
    localparam int POS_W  = $clog2(ROW_BITS);

    localparam logic [PIX_W-1:0]  C_PIX_LAST  = PIX_W'(NPIX - 1);
    localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(NBEATS - 1);
    localparam logic [BIT_W-1:0]  C_BITS_ALL  = BIT_W'(EDGE_COUNT);
    localparam logic [POS_W-1:0]  C_POS_LAST  = POS_W'(ROW_BITS - 1);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_BURST   = 2'd1,
        ST_COLLECT = 2'd2
    } state_t;

    state_t                r_state;
    logic [BIT_LENGTH-1:0] r_buf [NPIX];
    logic [PIX_W-1:0]      r_pix_cnt;
    logic [BEAT_W-1:0]     r_beat;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [POS_W-1:0]      r_row_pos;
    logic [ROW_BITS-1:0]   r_shift;
    logic [ROW_BITS-1:0]   r_row;
    logic                  r_m_valid;
    logic                  r_overflow;
    logic                  r_s_ready;
    logic                  r_busy;
    logic                  r_load_end;
    logic [BIT_LENGTH-1:0] r_lane [LANES];

    logic                  w_accept_px;
    logic [BEAT_W-1:0]     w_next_beat;
    logic [PIX_W-1:0]      w_rd_base;
    logic [BIT_LENGTH-1:0] w_next_lane [LANES];
    logic                  w_take;
    logic [ROW_BITS-1:0]   w_shift_next;
    logic                  w_row_done;
    logic                  w_hs;
    logic                  w_out_free;

    assign w_accept_px = r_s_ready && bus.s_valid;

    // In FILL this points at beat 0 so the first beat is ready on the accept edge
    assign w_next_beat = (r_state == ST_BURST) ? r_beat + 1'b1 : '0;
    assign w_rd_base   = PIX_W'(32'(w_next_beat) * LANES);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        assign w_next_lane[n] = r_buf[w_rd_base + PIX_W'(n)];
    end

    assign w_take       = (r_state == ST_COLLECT) && bus.readable_in && (r_bit_cnt != C_BITS_ALL);
    assign w_shift_next = {bus.edge_in, r_shift[ROW_BITS-1:1]};
    assign w_row_done   = w_take && (r_row_pos == C_POS_LAST);
    assign w_hs         = r_m_valid && bus.m_ready;
    assign w_out_free   = !r_m_valid || w_hs;

    always_ff @(posedge clk) begin
        if (w_accept_px) begin
            r_buf[r_pix_cnt] <= bus.s_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_FILL;
            r_pix_cnt  <= '0;
            r_beat     <= '0;
            r_bit_cnt  <= '0;
            r_row_pos  <= '0;
            r_shift    <= '0;
            r_row      <= '0;
            r_m_valid  <= 1'b0;
            r_overflow <= 1'b0;
            r_s_ready  <= 1'b1;
            r_busy     <= 1'b0;
            r_load_end <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                r_lane[n] <= '0;
            end
        end else begin
            if (w_hs) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                ST_FILL: begin
                    if (w_accept_px) begin
                        if (r_pix_cnt == C_PIX_LAST) begin
                            r_pix_cnt  <= '0;
                            r_beat     <= '0;
                            r_state    <= ST_BURST;
                            r_s_ready  <= 1'b0;
                            r_busy     <= 1'b1;
                            r_load_end <= 1'b0;
                            for (int n = 0; n < LANES; n++) begin
                                r_lane[n] <= w_next_lane[n];
                            end
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end

                ST_BURST: begin
                    if (r_beat == C_BEAT_LAST) begin
                        r_state    <= ST_COLLECT;
                        r_load_end <= 1'b0;
                        for (int n = 0; n < LANES; n++) begin
                            r_lane[n] <= '0;
                        end
                    end else begin
                        r_beat     <= w_next_beat;
                        r_load_end <= (w_next_beat == C_BEAT_LAST);
                        for (int n = 0; n < LANES; n++) begin
                            r_lane[n] <= w_next_lane[n];
                        end
                    end
                end

                ST_COLLECT: begin
                    if (w_take) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_shift   <= w_shift_next;
                        r_row_pos <= w_row_done ? '0 : r_row_pos + 1'b1;
                        // A finished row either replaces a departing one or is lost
                        if (w_row_done) begin
                            if (w_out_free) begin
                                r_row     <= w_shift_next;
                                r_m_valid <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                    if ((r_bit_cnt == C_BITS_ALL) && w_out_free) begin
                        r_state   <= ST_FILL;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_row_pos <= '0;
                    end
                end

                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.busy       = r_busy;
    assign bus.load_end   = r_load_end;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_row      = r_row;
    assign bus.overflow   = r_overflow;
    assign bus.pixel_out0 = r_lane[0];
    assign bus.pixel_out1 = r_lane[1];
    assign bus.pixel_out2 = r_lane[2];
    assign bus.pixel_out3 = r_lane[3];
    assign bus.pixel_out4 = r_lane[4];
endmodule
`default_nettype wire

// File: tb/tb_chip_frame_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_chip_frame_driver : scenario table plus frame/row reference model        |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module tb_chip_frame_driver;
    localparam int BL     = 5;
    localparam int DIM    = 20;
    localparam int LN     = 5;
    localparam int RB     = 20;
    localparam int EC     = 400;
    localparam int NPIX   = DIM * DIM;
    localparam int NBEATS = NPIX / LN;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chip_frame_driver_if #(.BIT_LENGTH(BL), .ROW_BITS(RB)) bus ();

    chip_frame_driver #(
        .BIT_LENGTH(BL), .IMG_DIM(DIM), .LANES(LN), .ROW_BITS(RB), .EDGE_COUNT(EC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int px [NPIX];

    // Reference model of the edge side: collected bits, output slot, sticky flag
    bit            m_mv;
    logic [RB-1:0] m_row;
    bit            m_ovf;
    int            nbits;
    bit            ebits [EC];

    typedef struct {
        int pix_mode;   // 0: i%32, 1: random
        int fill_mode;  // 0: valid held, 1: toggled, 2: random
        int rd_mode;    // 0: always, 1: 7-cycle gap mid-row, 2: random
        int edge_mode;  // 0: alternating starting at 1, 1: random
        int rdy_mode;   // 0: always, 1: low for 45 cycles, 2: random
        int exp_ovf;    // -1: not predetermined
        int exp_rows;   // -1: not predetermined
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lane_outs();
        return {36'd0, bus.s_ready, bus.busy, bus.load_end,
                bus.pixel_out4, bus.pixel_out3, bus.pixel_out2, bus.pixel_out1, bus.pixel_out0};
    endfunction

    function automatic logic [63:0] exp_lanes(input bit sr, input bit bz, input bit le, input int base);
        logic [63:0] e;
        e = '0;
        for (int n = 0; n < LN; n++) begin
            if (base >= 0) e[n*BL +: BL] = 5'(px[base + n]);
        end
        e[25] = le;
        e[26] = bz;
        e[27] = sr;
        return e;
    endfunction

    function automatic logic [63:0] all_outs();
        logic [63:0] o;
        o = lane_outs();
        o[28]    = bus.m_valid;
        o[48:29] = bus.m_row;
        o[49]    = bus.overflow;
        return o;
    endfunction

    function automatic logic [RB-1:0] pack(input int r);
        logic [RB-1:0] p;
        for (int i = 0; i < RB; i++) p[i] = ebits[r*RB + i];
        return p;
    endfunction

    task automatic model_reset();
        m_mv  = 0;
        m_row = '0;
        m_ovf = 0;
        nbits = 0;
    endtask

    // Streams one frame and checks burst beats 0..check_beats-1; returns showing beat check_beats
    task automatic run_fill(input int pix_mode, input int fill_mode, input int check_beats);
        int acc;
        int cyc;
        bit v;
        bit take;
        acc = 0;
        cyc = 0;
        for (int i = 0; i < NPIX; i++) px[i] = (pix_mode == 0) ? (i % 32) : int'($urandom % 32);
        while (acc < NPIX && cyc < 4000) begin
            v = (fill_mode == 0) ? 1'b1 : (fill_mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            bus.s_valid     = v;
            bus.s_pixel     = 5'(px[acc]);
            bus.readable_in = 1'($urandom % 2);
            bus.edge_in     = 1'($urandom % 2);
            bus.m_ready     = 1'($urandom % 2);
            take = v && bus.s_ready;
            step();
            if (take) acc++;
            cyc++;
        end
        bus.s_valid     = 1'b0;
        bus.readable_in = 1'b0;
        chk("fill_accepts", acc, NPIX);
        for (int k = 0; k < check_beats; k++) begin
            chk($sformatf("burst_beat%0d", k), lane_outs(), exp_lanes(1'b0, 1'b1, k == NBEATS - 1, k * LN));
            step();
        end
        if (check_beats == NBEATS) chk("burst_end", lane_outs(), exp_lanes(1'b0, 1'b1, 1'b0, -1));
    endtask

    task automatic run_collect(input int rd_mode, input int edge_mode, input int rdy_mode, output int rows);
        int  c;
        bit  done;
        bit  rd, ed, rdy, hs, pre_full, free;
        logic [63:0] act, exp;
        c    = 0;
        done = 0;
        rows = 0;
        nbits = 0;
        while (!done && c < 3000) begin
            rd  = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? !(c >= 25 && c < 32) : ($urandom % 4 != 0);
            ed  = (edge_mode == 0) ? (nbits % 2 == 0) : 1'($urandom % 2);
            rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (c >= 45) : 1'($urandom % 2);
            bus.readable_in = rd;
            bus.edge_in     = ed;
            bus.m_ready     = rdy;
            if (bus.m_valid && rdy) rows++;

            hs       = m_mv && rdy;
            pre_full = (nbits == EC);
            free     = !m_mv || hs;
            if (hs) m_mv = 0;
            if (rd && nbits < EC) begin
                ebits[nbits] = ed;
                nbits++;
                if (nbits % RB == 0) begin
                    if (free) begin
                        m_mv  = 1;
                        m_row = pack(nbits / RB - 1);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (pre_full && free) done = 1;

            step();
            c++;
            act = {39'd0, bus.m_valid, (m_mv ? bus.m_row : 20'd0), bus.overflow, bus.busy, bus.s_ready};
            exp = {39'd0, m_mv, (m_mv ? m_row : 20'd0), m_ovf, !done, done};
            chk($sformatf("collect_c%0d", c), act, exp);
        end
        bus.readable_in = 1'b0;
        chk("collect_done", done, 1);
    endtask

    initial begin
        int rows;
        vecs[0] = '{0, 0, 0, 0, 0,  0, 20};
        vecs[1] = '{0, 1, 0, 1, 0,  0, 20};
        vecs[2] = '{1, 2, 1, 0, 0,  0, 20};
        vecs[3] = '{1, 0, 0, 1, 1,  1, 19};
        vecs[4] = '{1, 2, 2, 1, 0,  1, 20};
        vecs[5] = '{0, 0, 0, 0, 0,  0, 20};
        vecs[6] = '{1, 2, 2, 1, 2, -1, -1};
        vecs[7] = '{1, 1, 2, 1, 2, -1, -1};

        reset           = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_pixel     = '0;
        bus.edge_in     = 1'b0;
        bus.readable_in = 1'b0;
        bus.m_ready     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("reset_state", all_outs(), exp_lanes(1'b1, 1'b0, 1'b0, -1));

        for (int v = 0; v < 8; v++) begin
            if (v == 5) begin
                // Abort a burst at beat 40 with an asynchronous reset
                run_fill(0, 0, 40);
                #2;
                reset = 1'b0;
                #1;
                chk("async_reset_midburst", all_outs(), exp_lanes(1'b1, 1'b0, 1'b0, -1));
                model_reset();
                @(negedge clk);
                reset = 1'b1;
                step();
                chk("after_reset_release", all_outs(), exp_lanes(1'b1, 1'b0, 1'b0, -1));
            end
            run_fill(vecs[v].pix_mode, vecs[v].fill_mode, NBEATS);
            run_collect(vecs[v].rd_mode, vecs[v].edge_mode, vecs[v].rdy_mode, rows);
            if (vecs[v].exp_ovf >= 0) chk($sformatf("v%0d_overflow", v), bus.overflow, 64'(vecs[v].exp_ovf));
            if (vecs[v].exp_rows >= 0) chk($sformatf("v%0d_rows", v), rows, 64'(vecs[v].exp_rows));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
